mem2_dbus_ctrl: RTL and testbench

- Sequences the data-bus transaction that spans the MEM and MEM2 stages.
- Load/store requests are issued from MEM; the read response is delivered to MEM2 as the DMOut source.
- Drives the MEM2 pipeline-register write enable and the stall to upstream stages.
- Discards responses that belong to flushed instructions, so the MEM2 result mux and WB never see stale load data.

---
 rtl/mem2_dbus_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mem2_dbus_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem2_dbus_ctrl.sv
// Data-bus transaction sequencer spanning the MEM and MEM2 stages.
// Optional sticky bus timeout flag is built when DBUS_TIMEOUT_EN is defined.
module mem2_dbus_ctrl #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_req_valid,
   input  logic              mem_req_wr,
   input  logic [ADDR_W-1:0] mem_req_addr,
   input  logic [DATA_W-1:0] mem_req_wdata,
   input  logic [3:0]        mem_req_wstrb,
   input  logic              mem_flush,
   input  logic              mem2_flush,
   output logic              dbus_req,
   output logic              dbus_wr,
   output logic [ADDR_W-1:0] dbus_addr,
   output logic [DATA_W-1:0] dbus_wdata,
   output logic [3:0]        dbus_wstrb,
   input  logic              dbus_addr_ok,
   input  logic              dbus_data_ok,
   input  logic [DATA_W-1:0] dbus_rdata,
   output logic [DATA_W-1:0] mem2_rdata,
   output logic              mem2_rdata_valid,
   output logic              pipe_stall,
   output logic              mem2_wr,
   output logic              busy,
   output logic              timeout_err
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDrain} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [3:0]        wstrb_q;
   logic              wr_q;
   logic              drop_q;
   logic              issue;

   always_comb begin
      dbus_req         = 1'b0;
      dbus_wr          = 1'b0;
      dbus_addr        = '0;
      dbus_wdata       = '0;
      dbus_wstrb       = 4'h0;
      pipe_stall       = 1'b0;
      mem2_rdata_valid = 1'b0;
      issue            = 1'b0;
      unique case (state_q)
         StIdle: issue = mem_req_valid & ~mem_flush;
         StReq: begin
            dbus_req   = 1'b1;
            dbus_wr    = wr_q;
            dbus_addr  = addr_q;
            dbus_wdata = wdata_q;
            dbus_wstrb = wstrb_q;
            pipe_stall = 1'b1;
         end
         StWait: begin
            pipe_stall       = ~dbus_data_ok;
            mem2_rdata_valid = dbus_data_ok & ~mem2_flush;
            // the response cycle frees the bus for the next request
            issue            = dbus_data_ok & mem_req_valid & ~mem_flush;
         end
         StDrain: pipe_stall = 1'b1;
         default: ;
      endcase
      if (issue) begin
         dbus_req   = 1'b1;
         dbus_wr    = mem_req_wr;
         dbus_addr  = mem_req_addr;
         dbus_wdata = mem_req_wdata;
         dbus_wstrb = mem_req_wstrb;
         if (state_q == StIdle && !dbus_addr_ok) pipe_stall = 1'b1;
      end
      // reset forces outputs idle without waiting for a clock edge
      if (rst) begin
         dbus_req         = 1'b0;
         dbus_wr          = 1'b0;
         dbus_addr        = '0;
         dbus_wdata       = '0;
         dbus_wstrb       = 4'h0;
         pipe_stall       = 1'b0;
         mem2_rdata_valid = 1'b0;
         issue            = 1'b0;
      end
   end

   assign mem2_wr    = ~pipe_stall;
   assign busy       = (state_q != StIdle);
   assign mem2_rdata = mem2_rdata_valid ? dbus_rdata : rdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         wstrb_q <= 4'h0;
         wr_q    <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         if (mem2_rdata_valid) rdata_q <= dbus_rdata;
         unique case (state_q)
            StIdle: ;
            StReq: begin
               if (dbus_addr_ok) begin
                  state_q <= (drop_q | mem_flush | mem2_flush) ? StDrain : StWait;
                  drop_q  <= 1'b0;
               end else begin
                  drop_q  <= drop_q | mem_flush | mem2_flush;
               end
            end
            StWait: begin
               if (dbus_data_ok)    state_q <= StIdle;
               else if (mem2_flush) state_q <= StDrain;
            end
            StDrain: if (dbus_data_ok) state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
         if (issue) begin
            if (dbus_addr_ok) begin
               state_q <= StWait;
            end else begin
               state_q <= StReq;
               addr_q  <= mem_req_addr;
               wdata_q <= mem_req_wdata;
               wstrb_q <= mem_req_wstrb;
               wr_q    <= mem_req_wr;
               drop_q  <= 1'b0;
            end
         end
      end
   end

`ifdef DBUS_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CntW-1:0] TmoMax = CntW'(TIMEOUT_CYCLES);

   logic [CntW-1:0] tmo_cnt_q;
   logic            tmo_q;
   logic            txn_end;

   // count restarts per transaction, including back-to-back ones
   assign txn_end = (state_q == StIdle) |
                    (((state_q == StWait) | (state_q == StDrain)) & dbus_data_ok);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_q <= '0;
         tmo_q     <= 1'b0;
      end else begin
         if (txn_end)                  tmo_cnt_q <= '0;
         else if (tmo_cnt_q != TmoMax) tmo_cnt_q <= tmo_cnt_q + 1'b1;
         if (busy && tmo_cnt_q == TmoMax - 1'b1) tmo_q <= 1'b1;
      end
   end

   assign timeout_err = tmo_q;
`else
   logic unused_tmo;
   assign unused_tmo  = ^TIMEOUT_CYCLES;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem2_dbus_ctrl.sv
// Scoreboard bench for mem2_dbus_ctrl: the bench acts as the cache and pushes expected
// load data when it drives a deliverable response; a monitor pops on mem2_rdata_valid.
module tb_mem2_dbus_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req_valid, mem_req_wr;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_flush, mem2_flush;
   logic        dbus_req, dbus_wr;
   logic [31:0] dbus_addr, dbus_wdata;
   logic [3:0]  dbus_wstrb;
   logic        dbus_addr_ok, dbus_data_ok;
   logic [31:0] dbus_rdata;
   logic [31:0] mem2_rdata;
   logic        mem2_rdata_valid, pipe_stall, mem2_wr, busy, timeout_err;

   int          n_vec  = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];

   mem2_dbus_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .mem_req_valid    (mem_req_valid),
      .mem_req_wr       (mem_req_wr),
      .mem_req_addr     (mem_req_addr),
      .mem_req_wdata    (mem_req_wdata),
      .mem_req_wstrb    (mem_req_wstrb),
      .mem_flush        (mem_flush),
      .mem2_flush       (mem2_flush),
      .dbus_req         (dbus_req),
      .dbus_wr          (dbus_wr),
      .dbus_addr        (dbus_addr),
      .dbus_wdata       (dbus_wdata),
      .dbus_wstrb       (dbus_wstrb),
      .dbus_addr_ok     (dbus_addr_ok),
      .dbus_data_ok     (dbus_data_ok),
      .dbus_rdata       (dbus_rdata),
      .mem2_rdata       (mem2_rdata),
      .mem2_rdata_valid (mem2_rdata_valid),
      .pipe_stall       (pipe_stall),
      .mem2_wr          (mem2_wr),
      .busy             (busy),
      .timeout_err      (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic quiet();
      mem_req_valid = 1'b0; mem_req_wr = 1'b0; mem_req_addr = '0; mem_req_wdata = '0;
      mem_req_wstrb = 4'h0; mem_flush = 1'b0; mem2_flush = 1'b0;
      dbus_addr_ok = 1'b0; dbus_data_ok = 1'b0; dbus_rdata = '0;
   endtask

   task automatic load(input logic [31:0] a, input logic aok);
      mem_req_valid = 1'b1; mem_req_wr = 1'b0; mem_req_addr = a; mem_req_wstrb = 4'h0;
      dbus_addr_ok = aok;
   endtask

   // monitor: every delivered word must match the oldest expected entry
   always @(negedge clk) begin
      if (!rst && mem2_rdata_valid) begin
         if (exp_q.size() == 0) begin
            check("sb_extra_valid", mem2_rdata_valid, 32'd0);
         end else begin
            check("sb_rdata", mem2_rdata, exp_q.pop_front());
            check("sb_mem2_wr", mem2_wr, 32'd1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      quiet();
      rst = 1'b1;
      #2;
      check("rst_busy", busy, 0);
      check("rst_stall", pipe_stall, 0);
      check("rst_mem2_wr", mem2_wr, 1);
      check("rst_rdata", mem2_rdata, 0);
      check("rst_req", dbus_req, 0);
      nxt(); nxt();
      rst = 1'b0;
      nxt();

      // flushed request in IDLE is never issued
      load(32'h50, 1'b1); mem_flush = 1'b1;
      smp(); check("flush_idle_req", dbus_req, 0);
      nxt(); quiet();
      smp(); check("flush_idle_busy", busy, 0);
      nxt();

      // load accepted immediately, data three cycles later
      load(32'h8000_0010, 1'b1);
      smp(); check("t1_req", dbus_req, 1); check("t1_addr", dbus_addr, 32'h8000_0010);
      check("t1_wr", dbus_wr, 0); check("t1_stall0", pipe_stall, 0);
      nxt(); quiet();
      for (int i = 0; i < 2; i++) begin
         smp(); check("t1_stall", pipe_stall, 1); check("t1_busy", busy, 1);
         check("t1_noreq", dbus_req, 0);
         nxt();
      end
      dbus_data_ok = 1'b1; dbus_rdata = 32'hDEAD_BEEF; exp_q.push_back(32'hDEAD_BEEF);
      smp(); check("t1_stall_dok", pipe_stall, 0); check("t1_valid", mem2_rdata_valid, 1);
      nxt(); quiet();
      smp(); check("t1_valid_one", mem2_rdata_valid, 0); check("t1_hold", mem2_rdata, 32'hDEAD_BEEF);
      check("t1_idle", busy, 0);
      nxt();

      // store held stable while addr_ok is withheld
      mem_req_valid = 1'b1; mem_req_wr = 1'b1; mem_req_addr = 32'h100;
      mem_req_wdata = 32'h1234_5678; mem_req_wstrb = 4'h3;
      smp(); check("t2_stall_idle", pipe_stall, 1); check("t2_req0", dbus_req, 1);
      nxt();
      for (int i = 1; i <= 4; i++) begin
         mem_req_wr = i[0]; mem_req_addr = $urandom; mem_req_wdata = $urandom;
         mem_req_wstrb = 4'(i + 8);
         dbus_addr_ok = (i == 4);
         smp();
         check("t2_req", dbus_req, 1); check("t2_wr", dbus_wr, 1);
         check("t2_addr", dbus_addr, 32'h100); check("t2_wdata", dbus_wdata, 32'h1234_5678);
         check("t2_wstrb", dbus_wstrb, 4'h3); check("t2_stall", pipe_stall, 1);
         nxt();
      end
      quiet();
      smp(); check("t2_wait_busy", busy, 1); check("t2_wait_noreq", dbus_req, 0);
      nxt();
      dbus_data_ok = 1'b1; dbus_rdata = 32'h5555_0000; exp_q.push_back(32'h5555_0000);
      smp(); nxt(); quiet();

      // mem2_flush during WAIT discards the response
      load(32'h200, 1'b1);
      smp(); nxt(); quiet();
      mem2_flush = 1'b1;
      smp(); check("t3_stall_flush", pipe_stall, 1);
      nxt(); quiet();
      load(32'h204, 1'b1);
      smp(); check("t3_drain_noreq", dbus_req, 0); check("t3_drain_stall", pipe_stall, 1);
      nxt(); quiet();
      dbus_data_ok = 1'b1; dbus_rdata = 32'hAAAA_AAAA;
      smp(); check("t3_discard", mem2_rdata_valid, 0); check("t3_hold", mem2_rdata, 32'h5555_0000);
      check("t3_drain_stall_dok", pipe_stall, 1);
      nxt(); quiet();
      load(32'h300, 1'b1);
      smp(); check("t3_idle", busy, 0); check("t3_next_req", dbus_req, 1);
      check("t3_next_addr", dbus_addr, 32'h300);
      nxt(); quiet();
      dbus_data_ok = 1'b1; dbus_rdata = 32'h0BAD_F00D; exp_q.push_back(32'h0BAD_F00D);
      smp(); nxt(); quiet();

      // back-to-back loads: second issued in the first's data_ok cycle
      load(32'h400, 1'b1);
      smp(); nxt(); quiet();
      smp(); nxt();
      dbus_data_ok = 1'b1; dbus_rdata = 32'h1111_1111; exp_q.push_back(32'h1111_1111);
      load(32'h404, 1'b1);
      smp(); check("t4_req2", dbus_req, 1); check("t4_addr2", dbus_addr, 32'h404);
      nxt(); quiet();
      smp(); check("t4_busy2", busy, 1); check("t4_stall2", pipe_stall, 1);
      nxt();
      dbus_data_ok = 1'b1; dbus_rdata = 32'h2222_2222; exp_q.push_back(32'h2222_2222);
      smp(); nxt(); quiet();
      smp(); check("t4_idle", busy, 0);
      nxt();

      // asynchronous reset in WAIT abandons the transaction
      load(32'h500, 1'b1);
      smp(); nxt(); quiet();
      smp(); check("t5_busy", busy, 1); check("t5_stall", pipe_stall, 1);
      #1 rst = 1'b1;
      #1;
      check("t5_rst_busy", busy, 0); check("t5_rst_stall", pipe_stall, 0);
      check("t5_rst_mem2_wr", mem2_wr, 1); check("t5_rst_rdata", mem2_rdata, 0);
      #1 rst = 1'b0;
      nxt();
      dbus_data_ok = 1'b1; dbus_rdata = 32'h9999_9999;
      smp(); check("t5_late_dok", mem2_rdata_valid, 0); check("t5_idle", busy, 0);
      check("t5_rdata", mem2_rdata, 0);
      nxt(); quiet();

      // outstanding load with no response: timeout flag behaviour
      load(32'h600, 1'b1);
      smp(); nxt(); quiet();
      for (int c = 1; c <= 15; c++) begin
         smp();
`ifdef DBUS_TIMEOUT_EN
         check("t6_tmo", timeout_err, (c >= 9) ? 32'd1 : 32'd0);
`else
         check("t6_tmo", timeout_err, 0);
`endif
         nxt();
      end
      rst = 1'b1;
      #1 check("t6_tmo_rst", timeout_err, 0);
      nxt();
      rst = 1'b0;
      nxt();

      check("sb_leftover", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
